// File: rtl/dump_stream.sv
// dump_stream: serialises squeezed SHAKE rate blocks into a W-bit
// word stream with byte-exact length tracking and a masked final word.
module dump_stream #(
    parameter int W         = 64,
    parameter int MAX_RATE  = 1344,
    parameter int LEN_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] output_size,
    input  logic [1:0]           operation_mode,
    input  logic                 block_valid,
    output logic                 block_ready,
    input  logic [MAX_RATE-1:0]  rate_output,
    output logic [W-1:0]         data_out,
    output logic [W/8-1:0]       data_keep,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 data_last,
    output logic                 busy,
    output logic                 done
);
    localparam int BPW = W / 8;
    localparam int SH  = $clog2(BPW);
    localparam int BW  = LEN_WIDTH - 3;
    localparam int CW  = $clog2(1344 / W + 1);

    localparam logic [1:0]    SHAKE256_MODE_VEC = 2'b11;
    localparam logic [CW-1:0] WORDS_256 = CW'(1088 / W);
    localparam logic [CW-1:0] WORDS_128 = CW'(1344 / W);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BLOCK,
        DRAIN
    } state_t;

    state_t              state;
    logic [MAX_RATE-1:0] shift_buf;
    logic [BW-1:0]       bytes_left;
    logic [CW-1:0]       rate_words;
    logic [CW-1:0]       word_cnt;

    logic [BW-1:0] start_bytes;
    logic [BW:0]   need_words;
    logic [CW-1:0] blk_words;
    logic [BW-1:0] step;
    logic [BW-1:0] bytes_next;
    logic          is_final;
    logic          unused_size_bits;

    assign start_bytes      = output_size[LEN_WIDTH-1:3];
    assign unused_size_bits = ^output_size[2:0];

    // Words still owed for the job, capped by what one block can supply
    assign need_words = ({1'b0, bytes_left} + (BW+1)'(BPW - 1)) >> SH;
    assign blk_words  = (need_words < (BW+1)'(rate_words))
                      ? CW'(need_words) : rate_words;

    assign is_final   = bytes_left <= BW'(BPW);
    assign step       = is_final ? bytes_left : BW'(BPW);
    assign bytes_next = bytes_left - step;

    assign block_ready = (state == WAIT_BLOCK);
    assign data_valid  = (state == DRAIN);
    assign busy        = (state != IDLE);
    assign data_last   = data_valid && is_final;

    // A short final word keeps only its top bytes; the rest read as zero
    always_comb begin
        data_keep = '0;
        data_out  = '0;
        for (int i = 0; i < BPW; i++) begin
            data_keep[i] = data_valid &&
                (!is_final || (BW'(i) + bytes_left >= BW'(BPW)));
            data_out[8*i +: 8] = data_keep[i] ? shift_buf[8*i +: 8] : 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift_buf  <= '0;
            bytes_left <= '0;
            rate_words <= '0;
            word_cnt   <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        bytes_left <= start_bytes;
                        rate_words <= (operation_mode == SHAKE256_MODE_VEC)
                                    ? WORDS_256 : WORDS_128;
                        if (start_bytes != '0) begin
                            state <= WAIT_BLOCK;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                WAIT_BLOCK: begin
                    if (block_valid) begin
                        shift_buf <= rate_output;
                        word_cnt  <= blk_words;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (data_ready) begin
                        shift_buf  <= shift_buf >> W;
                        word_cnt   <= word_cnt - CW'(1);
                        bytes_left <= bytes_next;
                        if (word_cnt == CW'(1)) begin
                            if (bytes_next == '0) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end else begin
                                state <= WAIT_BLOCK;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dump_stream.sv
// tb_dump_stream: randomized jobs on W=64 and W=32 instances checked
// against a byte-stream reference model built from the output rules.
module tb_dump_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start_a = 1'b0, start_b = 1'b0;
    logic          bv_a = 1'b0, bv_b = 1'b0;
    logic          data_ready = 1'b0;
    logic [31:0]   output_size = '0;
    logic [1:0]    mode = '0;
    logic [1343:0] rate = '0;

    logic        br_a, dv_a, dl_a, busy_a, done_a;
    logic        br_b, dv_b, dl_b, busy_b, done_b;
    logic [63:0] do_a;
    logic [31:0] do_b;
    logic [7:0]  dk_a;
    logic [3:0]  dk_b;

    bit          wide = 1'b1;
    logic        br, dv, dl, bsy, dn;
    logic [63:0] dout;
    logic [7:0]  dkeep;

    assign br    = wide ? br_a : br_b;
    assign dv    = wide ? dv_a : dv_b;
    assign dl    = wide ? dl_a : dl_b;
    assign bsy   = wide ? busy_a : busy_b;
    assign dn    = wide ? done_a : done_b;
    assign dout  = wide ? do_a : {32'h0, do_b};
    assign dkeep = wide ? dk_a : {4'h0, dk_b};

    int checks = 0;
    int failures = 0;

    dump_stream #(.W(64)) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .output_size(output_size), .operation_mode(mode),
        .block_valid(bv_a), .block_ready(br_a), .rate_output(rate),
        .data_out(do_a), .data_keep(dk_a), .data_valid(dv_a),
        .data_ready(data_ready), .data_last(dl_a),
        .busy(busy_a), .done(done_a)
    );

    dump_stream #(.W(32)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .output_size(output_size), .operation_mode(mode),
        .block_valid(bv_b), .block_ready(br_b), .rate_output(rate),
        .data_out(do_b), .data_keep(dk_b), .data_valid(dv_b),
        .data_ready(data_ready), .data_last(dl_b),
        .busy(busy_b), .done(done_b)
    );

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_start(bit v);
        if (wide) start_a = v; else start_b = v;
    endtask

    task automatic set_bv(bit v);
        if (wide) bv_a = v; else bv_b = v;
    endtask

    task automatic run_job(bit w, int nbits, bit s256, int stall);
        int bpw, rw, n, nw, nblk, t, k, b, cyc, hold;
        bit acc, fin, bvv;
        logic [1343:0] blks[$];
        logic [1343:0] tmp;
        logic [63:0] exp_d;
        logic [7:0]  exp_k;
        wide = w;
        bpw  = w ? 8 : 4;
        rw   = (s256 ? 136 : 168) / bpw;
        n    = nbits >> 3;
        nw   = (n + bpw - 1) / bpw;
        nblk = (nw + rw - 1) / rw;
        t    = n % bpw;
        for (int i = 0; i < nblk; i++) begin
            for (int j = 0; j < 42; j++) tmp[j*32 +: 32] = $urandom;
            blks.push_back(tmp);
        end
        @(negedge clk);
        output_size = nbits;
        mode = s256 ? 2'b11 : 2'($urandom_range(0, 2));
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        output_size = $urandom;
        mode = 2'($urandom);
        if (n == 0) begin
            check("zero_done", dn, 1);
            check("zero_busy", bsy, 0);
            check("zero_ready", br, 0);
            check("zero_valid", dv, 0);
            @(negedge clk);
            check("zero_done_pulse", dn, 0);
            check("zero_ready2", br, 0);
            return;
        end
        check("start_ready", br, 1);
        check("start_busy", bsy, 1);
        k = 0; b = 0; cyc = 0; hold = 0; acc = 1'b0;
        while (k < nw && cyc < 5000) begin
            if (acc) check("first_valid", dv, 1);
            check("no_early_done", dn, 0);
            check("busy_high", bsy, 1);
            if (br) check("no_extra_ready", b < nblk, 1);
            if (dv) begin
                check("valid_has_block", (k / rw) < b, 1);
                tmp   = blks[k / rw] >> ((k % rw) * bpw * 8);
                exp_d = tmp[63:0];
                if (!w) exp_d[63:32] = '0;
                fin   = (n - k * bpw) <= bpw;
                exp_k = w ? 8'hFF : 8'h0F;
                if (fin && t != 0) begin
                    for (int i = 0; i < 8; i++) begin
                        if (i < bpw - t) begin
                            exp_k[i] = 1'b0;
                            exp_d[i*8 +: 8] = 8'h00;
                        end
                    end
                end
                check("data_out", dout, exp_d);
                check("data_keep", dkeep, exp_k);
                check("data_last", dl, fin);
            end
            if (stall == 0) data_ready = 1'b1;
            else if (stall == 1) data_ready = 1'($urandom_range(0, 1));
            else if (dv && k >= 2) begin
                data_ready = (hold >= 5) && hold[0];
                hold++;
            end else data_ready = 1'b1;
            bvv = (b < nblk) && (stall != 1 || $urandom_range(0, 2) != 0);
            set_bv(bvv);
            rate = (b < nblk) ? blks[b] : {42{$urandom}};
            acc = br && bvv;
            if (acc) b++;
            if (dv && data_ready) k++;
            @(negedge clk);
            cyc++;
        end
        set_bv(1'b0);
        data_ready = 1'b0;
        check("word_count", k, nw);
        check("block_count", b, nblk);
        check("end_done", dn, 1);
        check("end_busy", bsy, 0);
        check("end_valid", dv, 0);
        check("end_ready", br, 0);
        @(negedge clk);
        check("done_pulse", dn, 0);
    endtask

    task automatic reset_test();
        logic [1343:0] v;
        wide = 1'b1;
        for (int j = 0; j < 42; j++) v[j*32 +: 32] = $urandom;
        @(negedge clk);
        output_size = 512;
        mode = 2'b00;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        bv_a = 1'b1;
        rate = v;
        data_ready = 1'b1;
        @(negedge clk);
        bv_a = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_valid", dv_a, 1);
        check("pre_reset_word3", do_a, v[255:192]);
        rst = 1'b1;
        #1;
        check("rst_data_out", do_a, 0);
        check("rst_keep", dk_a, 0);
        check("rst_valid", dv_a, 0);
        check("rst_last", dl_a, 0);
        check("rst_ready", br_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        @(negedge clk);
        rst = 1'b0;
        data_ready = 1'b0;
        run_job(1'b1, 128, 1'b0, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_do_a", do_a, 0);
        check("reset_keep_a", dk_a, 0);
        check("reset_ctl_a", {dv_a, dl_a, br_a, busy_a, done_a}, 0);
        check("reset_do_b", do_b, 0);
        check("reset_ctl_b", {dk_b, dv_b, dl_b, br_b, busy_b, done_b}, 0);
        rst = 1'b0;
        run_job(1'b1, 256, 1'b0, 0);
        run_job(1'b1, 2200, 1'b1, 0);
        run_job(1'b1, 1344, 1'b0, 2);
        run_job(1'b1, 5, 1'b0, 0);
        reset_test();
        run_job(1'b0, 1352, 1'b0, 0);
        run_job(1'b0, 2200, 1'b1, 2);
        repeat (25) begin
            run_job(1'($urandom_range(0, 1)), int'($urandom_range(0, 3000)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dump_stream.md
# dump_stream

Parametrised output stage for the SHAKE core that turns squeezed rate blocks into a byte-exact word stream. It accepts full rate blocks from the permutation stage over a valid/ready handshake. It serialises the blocks into `W`-bit words under downstream backpressure, tracks the requested output length across any number of blocks, and masks and flags the final partial word. It replaces the fixed 64-bit, handshake-less dump datapath and contains its own control FSM.

## Interface
- `W`, 64, output word width in bits; multiple of 8, must divide 1088 and 1344 (8/16/32/64).
- `MAX_RATE`, 1344, width of the rate input (`RATE_SHAKE128`).
- `LEN_WIDTH`, 32, width of the output-length field in bits.

- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: begin a squeeze job; sampled only in IDLE.
- `output_size` in LEN_WIDTH: requested output length in bits; bits [2:0] are ignored.
- `operation_mode` in 2: `SHAKE256_MODE_VEC` selects rate 1088; any other encoding selects rate 1344.
- `block_valid` in 1: a rate block is available.
- `block_ready` out 1: the block is accepted on `block_valid && block_ready`.
- `rate_output` in MAX_RATE: rate block; for rate 1088 only bits [1087:0] are used.
- `data_out` out W: output word; invalid bytes are zero.
- `data_keep` out W/8: byte-valid mask; bit i covers `data_out[8i+7:8i]`.
- `data_valid` out 1: output handshake, valid side.
- `data_ready` in 1: output handshake, ready side.
- `data_last` out 1: marks the final word of the job.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the job completes.

## Operation
- **Latched state:**
  - `bytes_left` = `output_size[LEN_WIDTH-1:3]`, (LEN_WIDTH-3) bits.
  - `rate_words` = 1088/W or 1344/W.
  - `tail` = `bytes_left mod (W/8)`.
- **IDLE:**
  - On `start` with `bytes_left != 0`, go to WAIT_BLOCK.
  - On `start` with `bytes_left == 0`, pulse `done` next cycle and stay in IDLE.
- **WAIT_BLOCK:**
  - `block_ready = 1`.
  - On accept, load the rate block into the shift buffer.
  - Load the word counter with `blk_words = min(rate_words, ceil(bytes_left / (W/8)))`.
  - Go to DRAIN.
- **DRAIN:**
  - `data_valid = 1`; `data_out` is the low W bits of the buffer, so word 0 is `rate_output[W-1:0]`.
  - On each `data_valid && data_ready`:
    - shift the buffer by W;
    - decrement the word counter;
    - decrement `bytes_left` by `min(W/8, bytes_left)`.
  - After the last word of the block: go to IDLE if `bytes_left` has reached 0, otherwise go to WAIT_BLOCK.
- **Final word:**
  - Applies when `bytes_left <= W/8` in DRAIN.
  - `data_last = 1`.
  - If `tail != 0`, only the top `tail` bytes are valid: `data_keep` has its top `tail` bits set and the lower bytes of `data_out` are forced to 0.
  - Otherwise `data_keep` is all ones.
- All non-final words have `data_keep` all ones and `data_last = 0`.
- Any number of blocks is supported; `bytes_left` never underflows.
- `start`, `output_size` and `operation_mode` are ignored while `busy`.
- `block_ready` is 0 outside WAIT_BLOCK.

## Timing
- **Reset values:**
  - FSM in IDLE; buffer and counters cleared.
  - `data_out=0`, `data_keep=0`, `data_valid=0`, `data_last=0`, `block_ready=0`, `busy=0`, `done=0`.
  - Reset during any state returns to these values immediately; the next `start` runs normally.
- **Latency:**
  - `start` at cycle N → `block_ready` at N+1.
  - Block accepted at N → first `data_valid` at N+1.
  - Final word transferred at N → `done=1` and `busy=0` at N+1.
  - Zero-length `start` at N → `done` at N+1.
- **Throughput and stability:**
  - One word per cycle while `data_ready=1`.
  - One bubble cycle between blocks for the WAIT_BLOCK accept.
  - While `data_valid && !data_ready`, `data_out`, `data_keep` and `data_last` hold stable.
- **Partial-block boundary:** when the last block of a job is partial, the remaining buffer words are discarded. The next job starts with a fresh block.

## Test plan
- **Single block, W=64, SHAKE128, output_size=256:** 1 block accepted → 4 words, `keep=FF` on each, `data_last` on the 4th, `done` one cycle later; `block_ready` never reasserts.
- **Multi-block with tail, W=64, SHAKE256, output_size=2200 (275 bytes):**
  - 3 blocks accepted: 17 + 17 + 1 words.
  - The final word has `keep=8'hE0`, `data_out[39:0]=0` and `data_out[63:40]` equal to rate bytes 5..7 of block 3 word 0.
- **Backpressure:** `data_ready` held low for 5 cycles mid-block, then toggled every cycle → output held stable while stalled; word count and order exact, no duplicate or lost words.
- **Zero length:** output_size=5 → `done` at N+1; `block_ready` and `data_valid` stay 0.
- **Reset mid-DRAIN:** `rst` pulsed after word 3 → all outputs 0 during reset; a new job (SHAKE128, 128 bits) then yields 2 correct words.
- **W=32, SHAKE128, output_size=1352 (169 bytes):** block 1 → 42 words; block 2 → 1 word with `keep=4'b1000` and `data_last=1`.
